pool_ctrl: RTL and testbench

//  Sequencer for the 2x2 pooling datapath (pair comparator, 13-deep row buffer, output buffer).

---
 rtl/pool_pkg.sv | 13 +
 rtl/pool_ctrl_mod_counter.sv | 20 ++
 rtl/pool_ctrl.sv | 88 ++++++++
 tb/tb_pool_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// pool_pkg: shared state encoding, pool-type codes and width helper for the pooling sequencer.
package pool_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t ROW_A = 2'd1;
  localparam state_t ROW_B = 2'd2;
  localparam state_t FLUSH = 2'd3;
  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pool_ctrl_mod_counter.sv
// mod_counter: modulo-MOD up counter with enable, clear and a combinational wrap flag.
module mod_counter
  import pool_pkg::*;
#(
  parameter int MOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic wrap
);
  localparam int W = cw(MOD);
  logic [W-1:0] cnt_q;
  assign wrap = en && cnt_q == W'(MOD - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt_q <= '0;
    else if (en) cnt_q <= wrap ? '0 : cnt_q + 1'b1;
  end
endmodule

// File: rtl/pool_ctrl.sv
// pool_ctrl: row-by-row sequencer for the 2x2 pooling datapath with output-buffer flush.
// Optional stall counter enabled by defining POOL_CTRL_PERF_EN.
module pool_ctrl
  import pool_pkg::*;
#(
  parameter int IMG_W = 26,
  parameter int IMG_H = 26,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             pool_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             en_comp1,
  output logic             en_comp2,
  output logic             pool_type,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int POOL_W  = IMG_W / 2;
  localparam int POOL_H  = IMG_H / 2;
  localparam int OSH_MAX = POOL_W * POOL_H + POOL_W - 1;
  localparam int OW      = cw(OSH_MAX + 1);
  localparam int RW      = cw(IMG_H);
  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [OW-1:0] osh_q, osh_d;
  logic          pool_type_q, rd_valid_q, done_q;
  logic          xfer, col_wrap, fl_wrap, start_acc, row_last;
  assign in_ready  = state_q == ROW_A || state_q == ROW_B;
  assign xfer      = in_valid && in_ready && !abort;
  assign en_comp1  = xfer;
  assign en_comp2  = (state_q == ROW_B && xfer) || (state_q == FLUSH && !abort);
  // done lands the cycle after FLUSH exits, so busy is stretched over it
  assign busy      = state_q != IDLE || done_q;
  assign start_acc = start && !abort && !busy;
  assign row_last  = row_q == RW'(IMG_H - 1);
  assign pool_type = pool_type_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  mod_counter #(.MOD(POOL_W)) u_col (
    .clk, .rst, .clr(!in_ready || abort), .en(xfer), .wrap(col_wrap)
  );
  mod_counter #(.MOD(POOL_W - 1)) u_flush (
    .clk, .rst, .clr(state_q != FLUSH || abort), .en(state_q == FLUSH && !abort), .wrap(fl_wrap)
  );
  always_comb begin
    state_d = abort              ? IDLE
            : state_q == IDLE    ? (start_acc ? ROW_A : IDLE)
            : state_q == ROW_A   ? (col_wrap ? ROW_B : ROW_A)
            : state_q == ROW_B   ? (col_wrap ? (row_last ? FLUSH : ROW_A) : ROW_B)
            :                      (fl_wrap ? IDLE : FLUSH);
    row_d   = (abort || start_acc) ? '0 : col_wrap ? (row_last ? '0 : row_q + 1'b1) : row_q;
    osh_d   = (abort || start_acc) ? '0 : osh_q + OW'(en_comp2);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      osh_q       <= '0;
      pool_type_q <= POOL_MAX;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      osh_q       <= osh_d;
      pool_type_q <= start_acc ? (pool_sel ? POOL_AVG : POOL_MAX) : pool_type_q;
      rd_valid_q  <= en_comp2 && osh_q >= OW'(POOL_W - 1);
      done_q      <= fl_wrap;
    end
  end
`ifdef POOL_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst || start_acc) stall_q <= '0;
    else if (in_ready && !in_valid && !(&stall_q)) stall_q <= stall_q + 1'b1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pool_ctrl.sv
// tb_pool_ctrl: randomized directed bench for pool_ctrl against a transfer-count reference model.
module tb_pool_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, start, abort, pool_sel, in_valid;
  int          sel;
  logic [1:0]  st_v, ab_v, iv_v, rdy, e1, e2, pt, rdv, bsy, dn;
  logic [15:0] sc0, sc1;
  assign st_v = sel == 1 ? {start, 1'b0} : {1'b0, start};
  assign ab_v = sel == 1 ? {abort, 1'b0} : {1'b0, abort};
  assign iv_v = sel == 1 ? {in_valid, 1'b0} : {1'b0, in_valid};
  pool_ctrl u_big (
    .clk, .rst, .start(st_v[0]), .abort(ab_v[0]), .pool_sel, .in_valid(iv_v[0]),
    .in_ready(rdy[0]), .en_comp1(e1[0]), .en_comp2(e2[0]), .pool_type(pt[0]),
    .rd_valid(rdv[0]), .busy(bsy[0]), .done(dn[0]), .stall_cnt(sc0)
  );
  pool_ctrl #(.IMG_W(4), .IMG_H(2)) u_small (
    .clk, .rst, .start(st_v[1]), .abort(ab_v[1]), .pool_sel, .in_valid(iv_v[1]),
    .in_ready(rdy[1]), .en_comp1(e1[1]), .en_comp2(e2[1]), .pool_type(pt[1]),
    .rd_valid(rdv[1]), .busy(bsy[1]), .done(dn[1]), .stall_cnt(sc1)
  );
  int n_cmp = 0, n_bad = 0;
  int pw, ph, mk, mf, mn, mstall;
  bit mact, mrdv, mdone, mpt;
  int o_e1, o_e2, o_rd, o_dn;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  // One clock of stimulus: check every output against the model, then advance the model
  task automatic cyc(bit r, bit v, bit st, bit ab, bit ps);
    int  t;
    bit  ex, fl, e2x, rows, acc, nrdv, ndone;
    int  exp_sc;
    t = 2 * ph * pw;
    @(negedge clk);
    rst = r; in_valid = v; start = st; abort = ab; pool_sel = ps;
    #1;
    rows = mact && mk < t;
    fl   = mact && mk == t;
    ex   = rows && v && !ab;
    e2x  = (ex && (mk / pw) % 2 == 1) || (fl && !ab);
`ifdef POOL_CTRL_PERF_EN
    exp_sc = mstall;
`else
    exp_sc = 0;
`endif
    chk("in_ready", rdy[sel], rows);
    chk("en_comp1", e1[sel], ex);
    chk("en_comp2", e2[sel], e2x);
    chk("rd_valid", rdv[sel], mrdv);
    chk("done", dn[sel], mdone);
    chk("busy", bsy[sel], mact || mdone);
    chk("pool_type", pt[sel], mpt);
    chk("stall_cnt", sel == 1 ? sc1 : sc0, exp_sc);
    o_e1 += e1[sel]; o_e2 += e2[sel]; o_rd += rdv[sel]; o_dn += dn[sel];
    nrdv  = e2x && mn + 1 >= pw;
    ndone = 0;
    if (rows && !v && mstall != 16'hffff) mstall++;
    mn += int'(e2x);
    if (ex) mk++;
    if (fl && !ab) begin
      mf++;
      if (mf == pw - 1) begin ndone = 1; mact = 0; end
    end
    acc = st && !ab && !(mact || mdone);
    if (ab) begin mact = 0; nrdv = 0; ndone = 0; end
    if (acc) begin mact = 1; mk = 0; mf = 0; mn = 0; mstall = 0; mpt = ps; end
    mrdv = nrdv; mdone = ndone;
    if (r) begin mact = 0; mrdv = 0; mdone = 0; mpt = 0; mstall = 0; end
  endtask
  task automatic run_frame(int pct, bit ps);
    o_e1 = 0; o_e2 = 0; o_rd = 0; o_dn = 0;
    cyc(0, 0, 1, 0, ps);
    for (int i = 0; i < 5000 && (mact || mdone); i++)
      cyc(0, $urandom_range(99) < pct, $urandom_range(9) == 0, 0, 1'($urandom_range(1)));
    cyc(0, 0, 0, 0, ps);
    chk("frame_busy_end", bsy[sel], 0);
    chk("frame_xfers", o_e1, 2 * ph * pw);
    chk("frame_en_comp2", o_e2, pw * ph + pw - 1);
    chk("frame_rd_valid", o_rd, pw * ph);
    chk("frame_done", o_dn, 1);
  endtask
  initial begin
    sel = 0; pw = 13; ph = 13;
    mk = 0; mf = 0; mn = 0; mstall = 0; mact = 0; mrdv = 0; mdone = 0; mpt = 0;
    rst = 1; start = 0; abort = 0; pool_sel = 0; in_valid = 0;
    repeat (3) @(posedge clk);
    cyc(0, 1, 0, 0, 1);
    run_frame(100, 0);
    run_frame(50, 1);
    // abort at row 7 col 5, then a clean frame
    o_dn = 0;
    cyc(0, 1, 1, 0, 0);
    for (int i = 0; i < 2000 && mk < 7 * pw + 5; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    chk("abort_no_done", o_dn, 0);
    run_frame(70, 0);
    // reset during FLUSH
    o_dn = 0;
    cyc(0, 1, 1, 0, 1);
    for (int i = 0; i < 2000 && !(mk == 2 * ph * pw && mf == 5); i++) cyc(0, 1, 0, 0, 1);
    cyc(1, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    chk("rst_pool_type", pt[0], 0);
    chk("rst_no_done", o_dn, 0);
    // start+abort together in IDLE is ignored
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 1);
    chk("start_abort_idle", bsy[0], 0);
    // small geometry: 4 xfers, one flush cycle, two outputs
    sel = 1; pw = 2; ph = 1;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    run_frame(100, 1);
    run_frame(60, 1);
    run_frame(40, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
